// File: rtl/ula_pkg.sv
// Shared definitions for the sequential ALU: control codes, aluOp classes,
// funct fields, FSM states and the control decoder.
package ula_pkg;

   typedef enum logic [3:0] {
      CTRL_AND   = 4'b0000,
      CTRL_OR    = 4'b0001,
      CTRL_ADD   = 4'b0010,
      CTRL_SUB   = 4'b0110,
      CTRL_SLT   = 4'b0111,
      CTRL_SLTU  = 4'b1000,
      CTRL_MULT  = 4'b1001,
      CTRL_MULTU = 4'b1010,
      CTRL_DIV   = 4'b1011,
      CTRL_NOR   = 4'b1100,
      CTRL_DIVU  = 4'b1101,
      CTRL_MFHI  = 4'b1110,
      CTRL_MFLO  = 4'b1111
   } ctrl_t;

   localparam logic [1:0] ALUOP_MEM   = 2'b00;
   localparam logic [1:0] ALUOP_BEQ   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;
   localparam logic [1:0] ALUOP_RSVD  = 2'b11;

   localparam logic [5:0] FUNCT_ADD   = 6'b100000;
   localparam logic [5:0] FUNCT_SUB   = 6'b100010;
   localparam logic [5:0] FUNCT_AND   = 6'b100100;
   localparam logic [5:0] FUNCT_OR    = 6'b100101;
   localparam logic [5:0] FUNCT_NOR   = 6'b100111;
   localparam logic [5:0] FUNCT_SLT   = 6'b101010;
   localparam logic [5:0] FUNCT_SLTU  = 6'b101011;
   localparam logic [5:0] FUNCT_MULT  = 6'b011000;
   localparam logic [5:0] FUNCT_MULTU = 6'b011001;
   localparam logic [5:0] FUNCT_DIV   = 6'b011010;
   localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
   localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
   localparam logic [5:0] FUNCT_MFLO  = 6'b010010;

   typedef enum logic [1:0] {
      OCIOSO = 2'b00,
      MULT   = 2'b01,
      DIV    = 2'b10,
      FIM    = 2'b11
   } state_t;

   typedef struct packed {
      ctrl_t ctrl;
      logic  invalid;
   } dec_t;

   // Unknown classes or funct fields fall back to AND and raise invalid.
   function automatic dec_t decode(input logic [1:0] aluop, input logic [5:0] funct);
      dec_t d;
      d.ctrl    = CTRL_AND;
      d.invalid = 1'b0;
      case (aluop)
         ALUOP_MEM:   d.ctrl = CTRL_ADD;
         ALUOP_BEQ:   d.ctrl = CTRL_SUB;
         ALUOP_RTYPE: begin
            case (funct)
               FUNCT_ADD:   d.ctrl = CTRL_ADD;
               FUNCT_SUB:   d.ctrl = CTRL_SUB;
               FUNCT_AND:   d.ctrl = CTRL_AND;
               FUNCT_OR:    d.ctrl = CTRL_OR;
               FUNCT_NOR:   d.ctrl = CTRL_NOR;
               FUNCT_SLT:   d.ctrl = CTRL_SLT;
               FUNCT_SLTU:  d.ctrl = CTRL_SLTU;
               FUNCT_MULT:  d.ctrl = CTRL_MULT;
               FUNCT_MULTU: d.ctrl = CTRL_MULTU;
               FUNCT_DIV:   d.ctrl = CTRL_DIV;
               FUNCT_DIVU:  d.ctrl = CTRL_DIVU;
               FUNCT_MFHI:  d.ctrl = CTRL_MFHI;
               FUNCT_MFLO:  d.ctrl = CTRL_MFLO;
               default:     d.invalid = 1'b1;
            endcase
         end
         default:     d.invalid = 1'b1;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/ula_mult_div.sv
// Iterative multiply/divide datapath: one shift-add or restoring-division
// bit per step on operand magnitudes, sign applied to the final step's result.
module ula_mult_div #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             step,
   input  logic             is_div,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             last,
   output logic [WIDTH-1:0] res_hi,
   output logic [WIDTH-1:0] res_lo
);

   localparam int CW = $clog2(WIDTH);

   logic [WIDTH-1:0]   hi_r, lo_r, op_r;
   logic [CW-1:0]      cnt;
   logic               div_r, neg_q, neg_r;
   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     sum, shifted;
   logic               ge;
   logic [WIDTH-1:0]   diff, nxt_hi, nxt_lo;
   logic [2*WIDTH-1:0] prod;

   always_comb begin
      a_neg = is_signed & a[WIDTH-1];
      b_neg = is_signed & b[WIDTH-1];
      a_mag = a_neg ? -a : a;
      b_mag = b_neg ? -b : b;
   end

   // hi_r: running upper product / partial remainder; lo_r: multiplier / dividend-quotient.
   // NOTE: every register here is a flop written with <=, so all branches see pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         hi_r  <= '0;
         lo_r  <= '0;
         op_r  <= '0;
         cnt   <= '0;
         div_r <= 1'b0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
      end else if (load) begin
         hi_r  <= '0;
         lo_r  <= a_mag;
         op_r  <= b_mag;
         cnt   <= '0;
         div_r <= is_div;
         neg_q <= a_neg ^ b_neg;
         neg_r <= a_neg;
      end else if (step) begin
         hi_r  <= nxt_hi;
         lo_r  <= nxt_lo;
         cnt   <= cnt + CW'(1);
      end
   end

   // NOTE: every output of this block is assigned before any branch, so no latch is inferred.
   always_comb begin
      sum     = {1'b0, hi_r} + {1'b0, (lo_r[0] ? op_r : {WIDTH{1'b0}})};
      shifted = {hi_r, lo_r[WIDTH-1]};
      ge      = shifted >= {1'b0, op_r};
      diff    = shifted[WIDTH-1:0] - op_r;
      nxt_hi  = sum[WIDTH:1];
      nxt_lo  = {sum[0], lo_r[WIDTH-1:1]};
      if (div_r) begin
         nxt_hi = ge ? diff : shifted[WIDTH-1:0];
         nxt_lo = {lo_r[WIDTH-2:0], ge};
      end
      prod = {nxt_hi, nxt_lo};
      if (neg_q) prod = -prod;
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
      if (div_r) begin
         res_lo = neg_q ? -nxt_lo : nxt_lo;
         res_hi = neg_r ? -nxt_hi : nxt_hi;
      end
   end

   assign last = (cnt == CW'(WIDTH-1));

endmodule

// File: rtl/ula_sequencial.sv
// Sequential MIPS-style ALU: single-cycle ops complete at the accepting edge,
// mult/div iterate WIDTH cycles in ula_mult_div and land in hi/lo.
module ula_sequencial
   import ula_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       aluOp,
   input  logic [5:0]       operacao,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             start,
   output logic [WIDTH-1:0] resultado,
   output logic             zero,
   output logic             done,
   output logic             busy,
   output logic             invalido
);

   state_t           state, state_nxt;
   dec_t             dec;
   logic [WIDTH-1:0] hi, lo, alu_res, md_hi, md_lo;
   logic             is_mul, is_div, is_signed, div_zero;
   logic             accept, load, step, finish, md_last;

   always_comb begin
      dec       = decode(aluOp, operacao);
      is_mul    = dec.ctrl inside {CTRL_MULT, CTRL_MULTU};
      is_div    = dec.ctrl inside {CTRL_DIV, CTRL_DIVU};
      is_signed = dec.ctrl inside {CTRL_MULT, CTRL_DIV};
      div_zero  = is_div && (b == '0);
   end

   always_comb begin
      alu_res = a & b;
      case (dec.ctrl)
         CTRL_OR:   alu_res = a | b;
         CTRL_ADD:  alu_res = a + b;
         CTRL_SUB:  alu_res = a - b;
         CTRL_NOR:  alu_res = ~(a | b);
         CTRL_SLT:  alu_res = WIDTH'($signed(a) < $signed(b));
         CTRL_SLTU: alu_res = WIDTH'(a < b);
         CTRL_MFHI: alu_res = hi;
         CTRL_MFLO: alu_res = lo;
         default:   alu_res = a & b;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= OCIOSO;
      else       state <= state_nxt;
   end

   // FIM is the done cycle; it accepts a new request exactly like OCIOSO.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      load      = 1'b0;
      step      = 1'b0;
      finish    = 1'b0;
      case (state)
         OCIOSO, FIM: begin
            state_nxt = OCIOSO;
            if (start) begin
               accept = 1'b1;
               if (is_mul) begin
                  load      = 1'b1;
                  state_nxt = MULT;
               end else if (is_div && !div_zero) begin
                  load      = 1'b1;
                  state_nxt = DIV;
               end
            end
         end
         MULT, DIV: begin
            step = 1'b1;
            if (md_last) begin
               finish    = 1'b1;
               state_nxt = FIM;
            end
         end
         default: state_nxt = OCIOSO;
      endcase
   end

   assign busy = (state == MULT) || (state == DIV);

   ula_mult_div #(.WIDTH(WIDTH)) u_mult_div (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .step      (step),
      .is_div    (is_div),
      .is_signed (is_signed),
      .a         (a),
      .b         (b),
      .last      (md_last),
      .res_hi    (md_hi),
      .res_lo    (md_lo)
   );

   // NOTE: hi/lo are architectural state visible through mfhi/mflo, so they are reset explicitly.
   always_ff @(posedge clk) begin
      if (reset) begin
         resultado <= '0;
         zero      <= 1'b1;
         done      <= 1'b0;
         invalido  <= 1'b0;
         hi        <= '0;
         lo        <= '0;
      end else begin
         done <= 1'b0;
         if (finish) begin
            hi        <= md_hi;
            lo        <= md_lo;
            resultado <= md_lo;
            zero      <= (md_lo == '0);
            invalido  <= 1'b0;
            done      <= 1'b1;
         end else if (accept && !load) begin
            done <= 1'b1;
            if (div_zero) begin
               hi        <= a;
               lo        <= '1;
               resultado <= '1;
               zero      <= 1'b0;
               invalido  <= 1'b0;
            end else begin
               resultado <= alu_res;
               zero      <= (alu_res == '0);
               invalido  <= dec.invalid;
            end
         end
      end
   end

endmodule

// File: tb/tb_ula_sequencial.sv
// Self-checking bench for ula_sequencial: directed vector table, multi-cycle
// corner sequences and randomized ops against an arithmetic reference model.
module tb_ula_sequencial;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  aluop;
   logic [5:0]  operacao;
   logic [31:0] a, b;
   logic        start;
   logic [31:0] resultado;
   logic        zero, done, busy, invalido;

   logic [1:0]  aluop8;
   logic [5:0]  operacao8;
   logic [7:0]  a8, b8;
   logic        start8;
   logic [7:0]  resultado8;
   logic        zero8, done8, busy8, invalido8;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] m_hi, m_lo;

   always #5 clk = ~clk;

   ula_sequencial #(.WIDTH(32)) u_dut (
      .clk(clk), .reset(reset), .aluOp(aluop), .operacao(operacao), .a(a), .b(b),
      .start(start), .resultado(resultado), .zero(zero), .done(done), .busy(busy),
      .invalido(invalido)
   );

   ula_sequencial #(.WIDTH(8)) u_dut8 (
      .clk(clk), .reset(reset), .aluOp(aluop8), .operacao(operacao8), .a(a8), .b(b8),
      .start(start8), .resultado(resultado8), .zero(zero8), .done(done8), .busy(busy8),
      .invalido(invalido8)
   );

   typedef struct {
      logic [1:0]  op;
      logic [5:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        zero;
      logic        inv;
      int          lat;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference model: ALU semantics straight from plain integer arithmetic.
   function automatic void model(input logic [1:0] op, input logic [5:0] f,
                                 input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] res, output logic inv, output int lat);
      logic [63:0] p;
      int sx, sy;
      res = x & y;
      inv = 1'b0;
      lat = 1;
      sx  = int'(x);
      sy  = int'(y);
      if (op == 2'b00) res = x + y;
      else if (op == 2'b01) res = x - y;
      else if (op == 2'b11) inv = 1'b1;
      else begin
         case (f)
            6'b100000: res = x + y;
            6'b100010: res = x - y;
            6'b100100: res = x & y;
            6'b100101: res = x | y;
            6'b100111: res = ~(x | y);
            6'b101010: res = (sx < sy) ? 32'd1 : 32'd0;
            6'b101011: res = (x < y) ? 32'd1 : 32'd0;
            6'b011000: begin
               p = longint'(sx) * longint'(sy);
               m_hi = p[63:32]; m_lo = p[31:0]; res = m_lo; lat = 33;
            end
            6'b011001: begin
               p = {32'h0, x} * {32'h0, y};
               m_hi = p[63:32]; m_lo = p[31:0]; res = m_lo; lat = 33;
            end
            6'b011010, 6'b011011: begin
               if (y == 32'h0) begin
                  m_lo = 32'hFFFFFFFF; m_hi = x;
               end else if (f == 6'b011011) begin
                  m_lo = x / y; m_hi = x % y; lat = 33;
               end else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin
                  m_lo = 32'h80000000; m_hi = 32'h0; lat = 33;
               end else begin
                  m_lo = sx / sy; m_hi = sx % sy; lat = 33;
               end
               res = m_lo;
            end
            6'b010000: res = m_hi;
            6'b010010: res = m_lo;
            default:   inv = 1'b1;
         endcase
      end
   endfunction

   // Issues one op, scrambles inputs after accept, waits (bounded) for done.
   task automatic run_op(input logic [1:0] op, input logic [5:0] f, input logic [31:0] x,
                         input logic [31:0] y, output logic [31:0] r, output logic z,
                         output logic inv, output int cyc, output int busy_bad);
      @(negedge clk);
      aluop = op; operacao = f; a = x; b = y; start = 1'b1;
      @(negedge clk);
      start = 1'b0; aluop = 2'($urandom); operacao = 6'($urandom); a = $urandom; b = $urandom;
      cyc = 1;
      busy_bad = 0;
      while (!done && cyc < 200) begin
         if (!busy) busy_bad++;
         @(negedge clk);
         cyc++;
      end
      if (busy) busy_bad++;
      r = resultado; z = zero; inv = invalido;
   endtask

   initial begin
      logic [31:0] r, mres;
      logic        z, inv, minv;
      int          cyc, bb, mlat, dcnt;
      logic [5:0]  fl[13];

      reset = 1'b1; start = 1'b0; aluop = 2'b00; operacao = 6'h0; a = '0; b = '0;
      start8 = 1'b0; aluop8 = 2'b00; operacao8 = 6'h0; a8 = '0; b8 = '0;
      m_hi = '0; m_lo = '0;
      repeat (3) @(negedge clk);
      check("rst_res", resultado, 32'h0);
      check("rst_zero", {31'h0, zero}, 32'h1);
      check("rst_flags", {29'h0, done, busy, invalido}, 32'h0);
      reset = 1'b0;

      tbl.push_back('{2'b10, 6'b100010, 32'd5,        32'd7,        32'hFFFFFFFE, 1'b0, 1'b0, 1});
      tbl.push_back('{2'b10, 6'b011000, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFEB, 1'b0, 1'b0, 33});
      tbl.push_back('{2'b10, 6'b010000, 32'h1,        32'h2,        32'hFFFFFFFF, 1'b0, 1'b0, 1});
      tbl.push_back('{2'b10, 6'b011010, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 1'b0, 33});
      tbl.push_back('{2'b10, 6'b010000, 32'h0,        32'h0,        32'hFFFFFFFF, 1'b0, 1'b0, 1});
      tbl.push_back('{2'b10, 6'b011011, 32'd7,        32'd0,        32'hFFFFFFFF, 1'b0, 1'b0, 1});
      tbl.push_back('{2'b10, 6'b010000, 32'h0,        32'h0,        32'd7,        1'b0, 1'b0, 1});
      tbl.push_back('{2'b11, 6'b111111, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h0,        1'b1, 1'b1, 1});
      tbl.push_back('{2'b01, 6'b000000, 32'd9,        32'd9,        32'h0,        1'b1, 1'b0, 1});
      tbl.push_back('{2'b00, 6'b000000, 32'hFFFFFFFF, 32'd1,        32'h0,        1'b1, 1'b0, 1});
      tbl.push_back('{2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1'b0, 1});
      tbl.push_back('{2'b10, 6'b101011, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b0, 1});
      tbl.push_back('{2'b10, 6'b011010, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b0, 33});
      tbl.push_back('{2'b10, 6'b010000, 32'h0,        32'h0,        32'h0,        1'b1, 1'b0, 1});
      tbl.push_back('{2'b10, 6'b100111, 32'h0,        32'h0,        32'hFFFFFFFF, 1'b0, 1'b0, 1});
      tbl.push_back('{2'b10, 6'b000000, 32'hFF,       32'h0F,       32'h0F,       1'b0, 1'b1, 1});
      tbl.push_back('{2'b10, 6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        1'b0, 1'b0, 33});
      tbl.push_back('{2'b10, 6'b010000, 32'h0,        32'h0,        32'hFFFFFFFE, 1'b0, 1'b0, 1});
      tbl.push_back('{2'b10, 6'b011010, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 1'b0, 33});
      tbl.push_back('{2'b10, 6'b010000, 32'h0,        32'h0,        32'd1,        1'b0, 1'b0, 1});

      foreach (tbl[i]) begin
         model(tbl[i].op, tbl[i].f, tbl[i].a, tbl[i].b, mres, minv, mlat);
         run_op(tbl[i].op, tbl[i].f, tbl[i].a, tbl[i].b, r, z, inv, cyc, bb);
         check($sformatf("tbl%0d_res", i), r, tbl[i].res);
         check($sformatf("tbl%0d_zero", i), {31'h0, z}, {31'h0, tbl[i].zero});
         check($sformatf("tbl%0d_inv", i), {31'h0, inv}, {31'h0, tbl[i].inv});
         check($sformatf("tbl%0d_lat", i), cyc, tbl[i].lat);
         check($sformatf("tbl%0d_busy", i), bb, 0);
      end

      // Back-to-back: a single-cycle op accepted in the done cycle of a mult, then another.
      model(2'b10, 6'b011000, 32'd6, 32'd7, mres, minv, mlat);
      @(negedge clk);
      aluop = 2'b10; operacao = 6'b011000; a = 32'd6; b = 32'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      while (!done && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      check("b2b_mult_lat", cyc, 33);
      check("b2b_mult_res", resultado, 32'd42);
      aluop = 2'b00; a = 32'd100; b = 32'd23; start = 1'b1;
      @(negedge clk);
      check("b2b_add_done", {31'h0, done}, 32'h1);
      check("b2b_add_res", resultado, 32'd123);
      aluop = 2'b10; operacao = 6'b100010; a = 32'd10; b = 32'd3;
      @(negedge clk);
      check("b2b_sub_done", {31'h0, done}, 32'h1);
      check("b2b_sub_res", resultado, 32'd7);
      start = 1'b0;
      @(negedge clk);
      check("b2b_done_pulse", {31'h0, done}, 32'h0);

      // Reset mid-multu: ignored add at cycle 5, reset at cycle 10.
      @(negedge clk);
      aluop = 2'b10; operacao = 6'b011001; a = 32'h1234; b = 32'h5678; start = 1'b1;
      dcnt = 0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (done) dcnt++;
         if (c == 5) begin aluop = 2'b00; a = 32'd1; b = 32'd2; start = 1'b1; end
         if (c == 9) check("abort_busy", {31'h0, busy}, 32'h1);
         if (c == 10) reset = 1'b1;
      end
      @(negedge clk);
      reset = 1'b0;
      check("abort_res", resultado, 32'h0);
      check("abort_zero", {31'h0, zero}, 32'h1);
      check("abort_flags", {29'h0, done, busy, invalido}, 32'h0);
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (done) dcnt++;
      end
      check("abort_no_done", dcnt, 0);
      m_hi = '0; m_lo = '0;
      run_op(2'b10, 6'b010000, 32'h0, 32'h0, r, z, inv, cyc, bb);
      check("abort_hi", r, 32'h0);
      run_op(2'b10, 6'b010010, 32'h0, 32'h0, r, z, inv, cyc, bb);
      check("abort_lo", r, 32'h0);

      // Randomized ops against the model.
      fl = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010, 6'b101011,
             6'b011000, 6'b011001, 6'b011010, 6'b011011, 6'b010000, 6'b010010};
      for (int n = 0; n < 60; n++) begin
         logic [1:0]  op;
         logic [5:0]  f;
         logic [31:0] x, y;
         int          k;
         k  = int'($urandom_range(0, 9));
         op = (k == 0) ? 2'b00 : (k == 1) ? 2'b01 : (k == 2) ? 2'b11 : 2'b10;
         k  = int'($urandom_range(0, 14));
         f  = (k < 13) ? fl[k] : 6'($urandom);
         x  = $urandom;
         y  = $urandom;
         if ($urandom_range(0, 7) == 0) y = 32'h0;
         if ($urandom_range(0, 3) == 0) y = y >> $urandom_range(8, 31);
         if ($urandom_range(0, 15) == 0) begin x = 32'h80000000; y = 32'hFFFFFFFF; end
         model(op, f, x, y, mres, minv, mlat);
         run_op(op, f, x, y, r, z, inv, cyc, bb);
         check($sformatf("rnd%0d_res op=%b f=%b a=%h b=%h", n, op, f, x, y), r, mres);
         check($sformatf("rnd%0d_zero", n), {31'h0, z}, {31'h0, (mres == 32'h0)});
         check($sformatf("rnd%0d_inv", n), {31'h0, inv}, {31'h0, minv});
         check($sformatf("rnd%0d_lat", n), cyc, mlat);
         check($sformatf("rnd%0d_busy", n), bb, 0);
      end

      // WIDTH=8 instance: multu 0xFF * 0xFF.
      @(negedge clk);
      aluop8 = 2'b10; operacao8 = 6'b011001; a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      cyc = 1;
      while (!done8 && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      check("w8_lat", cyc, 9);
      check("w8_lo", {24'h0, resultado8}, 32'h01);
      operacao8 = 6'b010000; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      check("w8_hi_done", {31'h0, done8}, 32'h1);
      check("w8_hi", {24'h0, resultado8}, 32'hFE);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
